// File: rtl/mux2_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit output channel between requesters A and B.
// Latency: request in IDLE -> grant next edge; granted beat -> y/y_valid one edge later.
// Backpressure: none on the output; a requester stalls by dropping req_x, which ends its grant.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_a/data_a/last_a      requester A: request/beat, data, final-beat marker
//   req_b/data_b/last_b      requester B: same meaning as A
//   gnt_a, gnt_b             current owner of the channel
//   sel                      mux select (0 = A, 1 = B); holds its value while idle
//   y, y_valid               registered output beat and its valid flag
//   busy                     a grant is active
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy
);

  // Encoding chosen so each grant output is a state flop bit directly.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_q;
  logic             prio_q;      // 0 = A wins a tie, 1 = B wins a tie
  logic [7:0]       hold_cnt_q;
  logic [7:0]       hold_cnt_d;
  logic             sel_q;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;

  // Owner-side view of the request, so both grant states share one path.
  logic             cur_req;
  logic             cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             release_w;

  always_comb begin
    cur_req    = (state_q == GRANT_B) ? req_b  : req_a;
    cur_last   = (state_q == GRANT_B) ? last_b : last_a;
    cur_data   = (state_q == GRANT_B) ? data_b : data_a;
    hold_cnt_d = hold_cnt_q + 8'd1;
    // Release on abandon, on the final beat, or on the MAX_HOLD-th beat.
    release_w  = !cur_req || cur_last || (hold_cnt_q == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      hold_cnt_q <= 8'd0;
      sel_q      <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          y_valid_q <= 1'b0;
          if (req_a && (!req_b || !prio_q)) begin
            state_q <= GRANT_A;
            sel_q   <= 1'b0;
          end else if (req_b) begin
            state_q <= GRANT_B;
            sel_q   <= 1'b1;
          end
        end
        GRANT_A, GRANT_B: begin
          if (cur_req) begin
            y_q        <= cur_data;
            y_valid_q  <= 1'b1;
            hold_cnt_q <= hold_cnt_d;
          end else begin
            y_valid_q  <= 1'b0;
          end
          // Hand priority to the other side even if it is not requesting;
          // the mandatory IDLE bubble follows every release.
          if (release_w) begin
            state_q    <= IDLE;
            hold_cnt_q <= 8'd0;
            prio_q     <= (state_q == GRANT_A);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_a   = state_q[0];
  assign gnt_b   = state_q[1];
  assign busy    = state_q[0] | state_q[1];
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
